shiftrows_pipe: RTL
===================

Name: shiftrows_pipe

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows stage for the pipelined AES/Rijndael datapath.
- Generalises the combinational 128-bit shiftrows to Rijndael block widths of Nb = 4, 6 or 8 columns.
- Direction is selected per transfer. A mode bit and a sideband tag travel with each word.
- Sits between the SubBytes and MixColumns stages. Uses a valid/ready handshake so downstream backpressure can stall the round pipeline.

Parameters:
- NB, 4, number of state columns. Legal values: 4, 6, 8. Block width is 32*NB.
- STAGES, 2, number of register stages. Legal range 1..4. Latency is STAGES cycles.
- TAG_W, 4, width of the sideband tag (round number or slot id) carried alongside the data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  stage 0 can accept the word this cycle.
- in_inv  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- in_data  in  32*NB  state. Byte index k = 4*c + r; byte 0 = in_data[7:0].
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts.
- out_inv  out  1  mode of the output word.
- out_tag  out  TAG_W  tag of the output word.
- out_data  out  32*NB  shifted state, same byte mapping as in_data.

Behaviour:
- Shift offsets per row r:
  - NB = 4 or 6: s = {0, 1, 2, 3}.
  - NB = 8: s = {0, 1, 3, 4}.
- ShiftRows: out[r][c] = in[r][(c + s[r]) mod NB].
- InvShiftRows: out[r][c] = in[r][(c - s[r] + NB) mod NB].
- Pure byte permutation. No arithmetic on byte values.
- Permutation is combinational on the inputs of stage 0. Stage 0 registers the permuted data together with inv and tag. Stages 1..STAGES-1 are plain forwarding registers. The last stage drives all out_* ports.
- Each stage i holds v[i] plus a payload (data, inv, tag).
- Ready chain:
  - rdy[STAGES-1] = !v[STAGES-1] || out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = rdy[0].
  - The ready path is combinational. A bubble in any stage is filled even while later stages are stalled.
- Stage i loads when rdy[i] is high:
  - v[i] takes the upstream valid (in_valid for stage 0).
  - The payload takes the upstream payload only when the upstream valid is 1. Otherwise the payload holds and v[i] goes to 0.
- When rdy[i] is low, the stage holds both v and payload.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Simultaneous input and output transfer on a full pipe is legal and sustains 1 word/cycle.
- Stability under stall: while out_valid && !out_ready, out_data, out_inv and out_tag stay stable.
- Latency: a word accepted at edge N is presented at out_* after edge N+STAGES-1, provided no stall occurs. Stalls add cycles one-for-one.
- Capacity: the pipe holds STAGES words. in_ready is low only when all stages are valid and out_ready is low.
- Mode and tag are per-word. Words of mixed mode may be interleaved back-to-back without a flush.
- Reset (rst_n low, asynchronous, any time including mid-stream):
  - All v[i] = 0 and all payload registers = 0.
  - Therefore out_valid = 0, out_data = 0, out_inv = 0, out_tag = 0.
  - in_ready = 1 combinationally once v is clear.
  - Words in flight are discarded.
  - Leaving reset needs no warm-up cycle.
- in_data, in_inv and in_tag are ignored when in_valid = 0.
- Out-of-range NB or STAGES must trigger an elaboration-time error. Nothing is silently clamped.

Test Plan:
- NB=4, STAGES=2, out_ready=1; in_data=128'h0F0E0D0C0B0A09080706050403020100, in_inv=0, tag=3 -> after 2 edges out_valid=1, out_data=128'h0B06010C07020D08030E09040F0A0500, out_tag=3, out_inv=0.
- Same NB/STAGES; in_data=128'h0B06010C07020D08030E09040F0A0500, in_inv=1 -> out_data=128'h0F0E0D0C0B0A09080706050403020100.
- Random encrypt word followed immediately by its inverse, 1000 random words -> each round trip returns the original word. Also check against a reference model for NB = 4, 6, 8 and STAGES = 1..4.
- NB=8; in_data bytes 0x00..0x1F (byte k = k), inv=0 -> out row2 col0 = 0x0E, out row3 col0 = 0x13, out row1 col7 = 0x01, row0 unchanged.
- Backpressure: stream 8 words with out_ready=0 for 5 cycles -> in_ready drops after STAGES words accepted; out_data stays stable while stalled. On release, all 8 words emerge in order with no loss or duplication. Then toggle out_ready every cycle -> no loss.
- Assert rst_n low while 2 words are in flight (asynchronous, mid-cycle) -> out_valid=0 and out_data=0 immediately, in_ready=1. After release, the next word emerges with correct latency and no stale word appears.

Source files
------------

// File: rtl/shiftrows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
// The permutation sits in front of stage 0; the remaining stages only forward data under valid/ready.
module shiftrows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_inv,
    output logic [TAG_W-1:0] out_tag,
    output logic [32*NB-1:0] out_data
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shiftrows_pipe: STAGES must be in 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shiftrows_pipe: TAG_W must be at least 1");
    end

    // Rijndael row offsets; Nb = 8 uses the wider spread for rows 2 and 3.
    function automatic int row_shift(input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    logic [W-1:0] perm;

    always_comb begin
        int src;
        perm = '0;
        src  = 0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = in_inv ? (c - row_shift(r) + NB) % NB : (c + row_shift(r)) % NB;
                perm[8*(4*c+r) +: 8] = in_data[8*(4*src+r) +: 8];
            end
        end
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] inv_q;
    logic [W-1:0]      data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    // A stage can load unless it and every stage after it is full while the sink stalls.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!v[j]) rdy[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            inv_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= perm;
                    inv_q[0]  <= in_inv;
                    tag_q[0]  <= in_tag;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        data_q[i] <= data_q[i-1];
                        inv_q[i]  <= inv_q[i-1];
                        tag_q[i]  <= tag_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign out_inv   = inv_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule
